// File: rtl/s0_rs_enc_lfsr_pkg.sv
// Shared constants for the t=2 RS(N,K) encoder over GF(2^8), field poly 0x11D.
// Generator g(x) = x^4 + 0F x^3 + 36 x^2 + 78 x + 40, roots a^0..a^3.
package rs_pkg;
  localparam int         RS_T    = 2;
  localparam int         RS_NPAR = 4;
  localparam logic [7:0] GF_POLY = 8'h1D;
  localparam logic [7:0] RS_G0   = 8'h40;
  localparam logic [7:0] RS_G1   = 8'h78;
  localparam logic [7:0] RS_G2   = 8'h36;
  localparam logic [7:0] RS_G3   = 8'h0F;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } rs_state_t;

  // Shift-and-add multiply; the x^8 overflow folds back through GF_POLY.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY : 8'h00);
    end
    return acc;
  endfunction
endpackage

// File: rtl/s0_rs_enc_lfsr_gf2m8_multi.sv
// GF(2^8) multiplier (poly 0x11D), purely combinational.
// Used with one operand tied to a generator coefficient, so it reduces to an XOR network.
module gf2m8_multi
  import rs_pkg::*;
(
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] z
);
  assign z = gf_mul(x, y);
endmodule

// File: rtl/s0_rs_enc_lfsr.sv
// Systematic RS(RS_K+4, RS_K) encoder: message symbols pass through, then 4 LFSR parity symbols.
// Optional macro RS_ENC_ICG_EN: LFSR/counter registers run on a gated clock instead of enable muxes.
module s0_rs_enc_lfsr
  import rs_pkg::*;
#(
  parameter int RS_K = 251
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       msg_vld,
  input  logic [7:0] msg_data,
  output logic       msg_rdy,
  output logic       cw_vld,
  output logic [7:0] cw_data,
  output logic       cw_sop,
  output logic       cw_eop,
  output logic       cw_par
);
  // Counter must also cover the 0..3 parity phase, hence the floor of 2 bits.
  localparam int CNT_W = ($clog2(RS_K + 1) < 2) ? 2 : $clog2(RS_K + 1);

  // Handshake: a symbol transfers on a rising edge where msg_vld & msg_rdy; the cw_* side has no backpressure.
  rs_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_lfsr;
  logic             r_cw_vld;
  logic [7:0]       r_cw_data;
  logic             r_cw_sop;
  logic             r_cw_eop;
  logic             r_cw_par;

  rs_state_t        w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      w_lfsr_nxt;
  logic             w_vld_nxt;
  logic [7:0]       w_data_nxt;
  logic             w_sop_nxt;
  logic             w_eop_nxt;
  logic             w_par_nxt;
  logic             w_accept;
  logic             w_ena;
  logic [7:0]       w_fb;
  logic [7:0]       w_m0;
  logic [7:0]       w_m1;
  logic [7:0]       w_m2;
  logic [7:0]       w_m3;

  assign msg_rdy  = (r_state == S_DATA);
  assign w_accept = msg_vld & msg_rdy;
  assign w_ena    = w_accept | (r_state == S_PAR);
  assign w_fb     = msg_data ^ r_lfsr[31:24];

  gf2m8_multi u_mul0 (.x(w_fb), .y(RS_G0), .z(w_m0));
  gf2m8_multi u_mul1 (.x(w_fb), .y(RS_G1), .z(w_m1));
  gf2m8_multi u_mul2 (.x(w_fb), .y(RS_G2), .z(w_m2));
  gf2m8_multi u_mul3 (.x(w_fb), .y(RS_G3), .z(w_m3));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lfsr_nxt  = r_lfsr;
    w_vld_nxt   = 1'b0;
    w_data_nxt  = r_cw_data;
    w_sop_nxt   = 1'b0;
    w_eop_nxt   = 1'b0;
    w_par_nxt   = 1'b0;
    case (r_state)
      S_DATA: begin
        if (w_accept) begin
          w_lfsr_nxt = {r_lfsr[23:16] ^ w_m3, r_lfsr[15:8] ^ w_m2, r_lfsr[7:0] ^ w_m1, w_m0};
          w_vld_nxt  = 1'b1;
          w_data_nxt = msg_data;
          w_sop_nxt  = (r_cnt == '0);
          if (r_cnt == CNT_W'(RS_K - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_PAR;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_PAR: begin
        w_vld_nxt  = 1'b1;
        w_par_nxt  = 1'b1;
        w_data_nxt = r_lfsr[31:24];
        w_lfsr_nxt = {r_lfsr[23:0], 8'h00};
        if (r_cnt == CNT_W'(3)) begin
          w_eop_nxt   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_DATA;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_DATA;
      r_cw_vld  <= 1'b0;
      r_cw_data <= 8'h00;
      r_cw_sop  <= 1'b0;
      r_cw_eop  <= 1'b0;
      r_cw_par  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cw_vld  <= w_vld_nxt;
      r_cw_data <= w_data_nxt;
      r_cw_sop  <= w_sop_nxt;
      r_cw_eop  <= w_eop_nxt;
      r_cw_par  <= w_par_nxt;
    end
  end

`ifdef RS_ENC_ICG_EN
  logic w_gclk;

  icg u_icg (.clk(clk), .en(w_ena), .gclk(w_gclk));

  always_ff @(posedge w_gclk or negedge rstn) begin
    if (!rstn) begin
      r_lfsr <= 32'h0;
      r_cnt  <= '0;
    end else begin
      r_lfsr <= w_lfsr_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lfsr <= 32'h0;
      r_cnt  <= '0;
    end else if (w_ena) begin
      r_lfsr <= w_lfsr_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end
`endif

  assign cw_vld  = r_cw_vld;
  assign cw_data = r_cw_data;
  assign cw_sop  = r_cw_sop;
  assign cw_eop  = r_cw_eop;
  assign cw_par  = r_cw_par;
endmodule

// File: tb/tb_s0_rs_enc_lfsr.sv
// Directed bench for s0_rs_enc_lfsr: RS_K=251 main instance plus an RS_K=1 instance.
// Captured symbols are {sop, eop, par, data}; syndromes of captured codewords must be zero.
module tb_s0_rs_enc_lfsr;
  localparam int K = 251;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       msg_vld = 1'b0, msg_rdy, cw_vld, cw_sop, cw_eop, cw_par;
  logic [7:0] msg_data = 8'h00, cw_data;
  logic       msg_vld1 = 1'b0, msg_rdy1, cw_vld1, cw_sop1, cw_eop1, cw_par1;
  logic [7:0] msg_data1 = 8'h00, cw_data1;

  logic [10:0] cap_q[$];
  logic [10:0] cap1_q[$];
  logic [10:0] exp_q[$];
  logic [7:0]  msg_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_low = 0;
  int last_eop_cyc = -100;
  int sop_gap = -1;

  s0_rs_enc_lfsr #(.RS_K(K)) u_dut (
    .clk(clk), .rstn(rstn), .msg_vld(msg_vld), .msg_data(msg_data), .msg_rdy(msg_rdy),
    .cw_vld(cw_vld), .cw_data(cw_data), .cw_sop(cw_sop), .cw_eop(cw_eop), .cw_par(cw_par)
  );

  s0_rs_enc_lfsr #(.RS_K(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .msg_vld(msg_vld1), .msg_data(msg_data1), .msg_rdy(msg_rdy1),
    .cw_vld(cw_vld1), .cw_data(cw_data1), .cw_sop(cw_sop1), .cw_eop(cw_eop1), .cw_par(cw_par1)
  );

  // clock / reset
  always #5 clk = ~clk;

  // monitor
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!msg_rdy) rdy_low = rdy_low + 1;
    if (cw_vld) begin
      cap_q.push_back({cw_sop, cw_eop, cw_par, cw_data});
      if (cw_sop) sop_gap = cyc - last_eop_cyc;
      if (cw_eop) last_eop_cyc = cyc;
    end
    if (cw_vld1) cap1_q.push_back({cw_sop1, cw_eop1, cw_par1, cw_data1});
  end

  // reference GF multiply, MSB-first Horner form
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    msg_vld = 1'b0;
    repeat (8) step();
  endtask

  task automatic fill_rand();
    msg_q.delete();
    for (int i = 0; i < K; i++) msg_q.push_back(8'($urandom_range(255)));
  endtask

  // driver: msg_vld stays high while waiting on msg_rdy, random gaps only before a symbol
  task automatic send(input int gap_pct);
    for (int i = 0; i < msg_q.size(); i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        msg_vld = 1'b0;
        step();
      end
      msg_vld  = 1'b1;
      msg_data = msg_q[i];
      for (int w = 0; w < 20 && !msg_rdy; w++) step();
      if (!msg_rdy) check("rdy_timeout", 32'(msg_rdy), 32'd1);
      step();
    end
    msg_vld = 1'b0;
  endtask

  // scoreboard model: append expected codeword for msg_q
  task automatic build_exp();
    logic [7:0] p[4];
    logic [7:0] fb;
    for (int j = 0; j < 4; j++) p[j] = 8'h00;
    for (int i = 0; i < msg_q.size(); i++) begin
      exp_q.push_back({(i == 0), 1'b0, 1'b0, msg_q[i]});
      fb   = msg_q[i] ^ p[3];
      p[3] = p[2] ^ tb_mul(fb, 8'h0F);
      p[2] = p[1] ^ tb_mul(fb, 8'h36);
      p[1] = p[0] ^ tb_mul(fb, 8'h78);
      p[0] = tb_mul(fb, 8'h40);
    end
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back({1'b0, (j == 3), 1'b1, p[3]});
      p[3] = p[2]; p[2] = p[1]; p[1] = p[0]; p[0] = 8'h00;
    end
  endtask

  task automatic syn_check(input string tag);
    logic [7:0] s;
    logic [7:0] aj;
    aj = 8'h01;
    for (int j = 0; j < 4; j++) begin
      s = 8'h00;
      foreach (cap_q[i]) s = tb_mul(s, aj) ^ cap_q[i][7:0];
      check($sformatf("%s_syn%0d", tag, j), 32'(s), 32'h0);
      aj = tb_mul(aj, 8'h02);
    end
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_len"}, 32'(cap_q.size()), 32'(exp_q.size()));
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_sym%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [10:0] lit1[5];
    logic [7:0]  par3[4];
    lit1 = '{11'h401, 11'h10F, 11'h136, 11'h178, 11'h340};
    par3 = '{8'h0F, 8'h36, 8'h78, 8'h40};

    repeat (3) step();
    check("rst_vld", 32'(cw_vld), 32'd0);
    check("rst_data", 32'(cw_data), 32'h0);
    check("rst_flags", 32'({cw_sop, cw_eop, cw_par}), 32'd0);
    check("rst_rdy", 32'(msg_rdy), 32'd1);
    check("rst_rdy1", 32'(msg_rdy1), 32'd1);
    rstn = 1'b1;
    step();

    // K=1, msg 01
    msg_vld1 = 1'b1; msg_data1 = 8'h01;
    step();
    msg_vld1 = 1'b0;
    repeat (8) step();
    check("k1_len", 32'(cap1_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < cap1_q.size(); i++) check($sformatf("k1_sym%0d", i), 32'(cap1_q[i]), 32'(lit1[i]));

    // all-zero message
    msg_q.delete();
    for (int i = 0; i < K; i++) msg_q.push_back(8'h00);
    rdy_low = 0;
    send(0);
    drain();
    check("zero_rdy_low", 32'(rdy_low), 32'd4);
    build_exp();
    compare("zero");

    // 250 zeros then 01, without and with gaps
    msg_q[K-1] = 8'h01;
    for (int g = 0; g < 2; g++) begin
      send(g * 30);
      drain();
      for (int j = 0; j < 4; j++)
        if (cap_q.size() == K + 4) check($sformatf("unit%0d_par%0d", g, j), 32'(cap_q[K+j][7:0]), 32'(par3[j]));
      check($sformatf("unit%0d_n", g), 32'(cap_q.size()), 32'(K + 4));
      build_exp();
      compare($sformatf("unit%0d", g));
    end

    // back-to-back codewords with msg_vld held high
    rdy_low = 0;
    fill_rand(); build_exp(); send(0);
    fill_rand(); build_exp(); send(0);
    drain();
    check("b2b_sop_gap", 32'(sop_gap), 32'd1);
    check("b2b_rdy_low", 32'(rdy_low), 32'd8);
    compare("b2b");

    // reset during the 2nd parity cycle
    fill_rand();
    send(0);
    step();
    step();
    rstn = 1'b0;
    #1;
    check("mid_rst_vld", 32'(cw_vld), 32'd0);
    check("mid_rst_flags", 32'({cw_sop, cw_eop, cw_par, cw_data}), 32'd0);
    check("mid_rst_rdy", 32'(msg_rdy), 32'd1);
    step();
    rstn = 1'b1;
    step();
    cap_q.delete();
    exp_q.delete();
    fill_rand(); build_exp(); send(10); drain();
    syn_check("post_rst");
    compare("post_rst");

    // random messages with gaps
    for (int r = 0; r < 2; r++) begin
      fill_rand(); build_exp(); send(20); drain();
      syn_check($sformatf("rnd%0d", r));
      compare($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
